// File: rtl/mac_tx_arbiter.sv
// Packet-granular round-robin arbiter feeding the 64-bit TX AXI-Stream.
// Optional per-port frame / stall counters: MAC_TX_ARBITER_STATS_EN.
module mac_tx_arbiter #(
   parameter int NUM_PORTS = 2,
   parameter int GRANT_W   = 3
) (
   input  logic                   clk156,
   input  logic                   aresetn,
   input  logic [NUM_PORTS*64-1:0] s_axis_tdata,
   input  logic [NUM_PORTS*8-1:0]  s_axis_tkeep,
   input  logic [NUM_PORTS-1:0]    s_axis_tvalid,
   input  logic [NUM_PORTS-1:0]    s_axis_tlast,
   output logic [NUM_PORTS-1:0]    s_axis_tready,
   output logic [63:0]             m_axis_tdata,
   output logic [7:0]              m_axis_tkeep,
   output logic                    m_axis_tvalid,
   output logic                    m_axis_tlast,
   input  logic                    m_axis_tready,
   output logic [GRANT_W-1:0]      grant_id,
   output logic                    busy
`ifdef MAC_TX_ARBITER_STATS_EN
   ,
   output logic [NUM_PORTS*32-1:0] frame_count,
   output logic [31:0]             stall_count
`endif
);

   typedef enum logic {
      IDLE,
      STREAM
   } state_t;

   localparam logic [GRANT_W-1:0] LAST_RST = GRANT_W'(NUM_PORTS - 1);

   state_t               state;
   state_t               state_nxt;
   logic [GRANT_W-1:0]   last_grant;
   logic [GRANT_W-1:0]   winner;
   logic [GRANT_W-1:0]   win_hi;
   logic [GRANT_W-1:0]   win_lo;
   logic                 found_hi;
   logic                 any_req;
   logic [63:0]          sel_data;
   logic [7:0]           sel_keep;
   logic                 sel_valid;
   logic                 sel_last;
   logic [NUM_PORTS-1:0] sel_hot;
   logic                 eof;

   assign any_req = |s_axis_tvalid;
   assign busy    = (state == STREAM);
   assign eof     = busy & sel_valid & m_axis_tready & sel_last;

   // Round-robin pick: lowest requester above last_grant, else lowest overall.
   always_comb begin
      win_hi   = '0;
      win_lo   = '0;
      found_hi = 1'b0;
      for (int i = NUM_PORTS - 1; i >= 0; i--) begin
         if (s_axis_tvalid[i]) begin
            if (GRANT_W'(i) > last_grant) begin
               win_hi   = GRANT_W'(i);
               found_hi = 1'b1;
            end else begin
               win_lo = GRANT_W'(i);
            end
         end
      end
      winner = found_hi ? win_hi : win_lo;
   end

   // Select the granted port's stream signals.
   always_comb begin
      sel_data  = '0;
      sel_keep  = '0;
      sel_valid = 1'b0;
      sel_last  = 1'b0;
      sel_hot   = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (grant_id == GRANT_W'(i)) begin
            sel_data   = s_axis_tdata[i*64 +: 64];
            sel_keep   = s_axis_tkeep[i*8 +: 8];
            sel_valid  = s_axis_tvalid[i];
            sel_last   = s_axis_tlast[i];
            sel_hot[i] = 1'b1;
         end
      end
   end

   // Next state and pass-through outputs; everything quiet outside STREAM.
   always_comb begin
      state_nxt     = state;
      m_axis_tdata  = '0;
      m_axis_tkeep  = '0;
      m_axis_tvalid = 1'b0;
      m_axis_tlast  = 1'b0;
      s_axis_tready = '0;
      unique case (state)
         IDLE: begin
            if (any_req)
               state_nxt = STREAM;
         end
         STREAM: begin
            m_axis_tdata  = sel_data;
            m_axis_tkeep  = sel_keep;
            m_axis_tvalid = sel_valid;
            m_axis_tlast  = sel_last;
            s_axis_tready = sel_hot & {NUM_PORTS{m_axis_tready}};
            if (eof)
               state_nxt = IDLE;
         end
      endcase
   end

   // State register plus grant bookkeeping.
   always_ff @(posedge clk156 or negedge aresetn) begin
      if (!aresetn) begin
         state      <= IDLE;
         last_grant <= LAST_RST;
         grant_id   <= '0;
      end else begin
         state <= state_nxt;
         if (state == IDLE && any_req)
            grant_id <= winner;
         if (eof)
            last_grant <= grant_id;
      end
   end

`ifdef MAC_TX_ARBITER_STATS_EN
   // Wrapping counters of completed frames per port and stalled cycles.
   always_ff @(posedge clk156 or negedge aresetn) begin
      if (!aresetn) begin
         frame_count <= '0;
         stall_count <= '0;
      end else begin
         for (int i = 0; i < NUM_PORTS; i++) begin
            if (eof && grant_id == GRANT_W'(i))
               frame_count[i*32 +: 32] <= frame_count[i*32 +: 32] + 32'd1;
         end
         if (busy & m_axis_tvalid & ~m_axis_tready)
            stall_count <= stall_count + 32'd1;
      end
   end
`endif

`ifndef SYNTHESIS
   // Stalled output beat must not change until it is accepted.
   a_stable : assert property (@(posedge clk156) disable iff (!aresetn)
      (m_axis_tvalid && !m_axis_tready) |=>
         ($stable(m_axis_tdata) && $stable(m_axis_tkeep) &&
          $stable(m_axis_tlast)));

   // Only the granted requester may ever see ready.
   a_onehot : assert property (@(posedge clk156) disable iff (!aresetn)
      $onehot0(s_axis_tready));
`endif

endmodule

// File: tb/tb_mac_tx_arbiter.sv
// Directed bench for mac_tx_arbiter with three requesters.
// Counter checks are compiled in when MAC_TX_ARBITER_STATS_EN is defined.
module tb_mac_tx_arbiter;

   localparam int NP = 3;
   localparam int GW = 2;

   logic            clk156 = 1'b0;
   logic            aresetn;
   logic [NP*64-1:0] s_tdata;
   logic [NP*8-1:0]  s_tkeep;
   logic [NP-1:0]    s_tvalid;
   logic [NP-1:0]    s_tlast;
   logic [NP-1:0]    s_tready;
   logic [63:0]      m_tdata;
   logic [7:0]       m_tkeep;
   logic             m_tvalid;
   logic             m_tlast;
   logic             m_tready;
   logic [GW-1:0]    grant_id;
   logic             busy;
`ifdef MAC_TX_ARBITER_STATS_EN
   logic [NP*32-1:0] frame_count;
   logic [31:0]      stall_count;
`endif

   int n_pass;
   int n_total;

   logic [72:0] mem [NP][32];
   int          wr [NP];
   int          rd [NP];

   logic [63:0] log_data [64];
   int          log_port [64];
   int          log_cyc  [64];
   int          nlog;
   int          cyc;

   always #5 clk156 = ~clk156;

   mac_tx_arbiter #(
      .NUM_PORTS(NP),
      .GRANT_W  (GW)
   ) dut (
      .clk156       (clk156),
      .aresetn      (aresetn),
      .s_axis_tdata (s_tdata),
      .s_axis_tkeep (s_tkeep),
      .s_axis_tvalid(s_tvalid),
      .s_axis_tlast (s_tlast),
      .s_axis_tready(s_tready),
      .m_axis_tdata (m_tdata),
      .m_axis_tkeep (m_tkeep),
      .m_axis_tvalid(m_tvalid),
      .m_axis_tlast (m_tlast),
      .m_axis_tready(m_tready),
      .grant_id     (grant_id),
      .busy         (busy)
`ifdef MAC_TX_ARBITER_STATS_EN
      ,
      .frame_count  (frame_count),
      .stall_count  (stall_count)
`endif
   );

   task automatic present_all();
      logic [72:0] w;
      for (int i = 0; i < NP; i++) begin
         if (rd[i] < wr[i]) begin
            w = mem[i][rd[i]];
            s_tvalid[i]          = 1'b1;
            s_tlast[i]           = w[72];
            s_tkeep[i*8 +: 8]    = w[71:64];
            s_tdata[i*64 +: 64]  = w[63:0];
         end else begin
            s_tvalid[i]          = 1'b0;
            s_tlast[i]           = 1'b0;
            s_tkeep[i*8 +: 8]    = '0;
            s_tdata[i*64 +: 64]  = '0;
         end
      end
   endtask

   task automatic clear_src();
      for (int i = 0; i < NP; i++) begin
         wr[i] = 0;
         rd[i] = 0;
      end
      present_all();
   endtask

   task automatic push(input int p, input int n,
                       input logic [63:0] base,
                       input logic [7:0] lkeep);
      logic       lst;
      logic [7:0] k;
      for (int b = 0; b < n; b++) begin
         lst = (b == n - 1);
         k   = lst ? lkeep : 8'hFF;
         mem[p][wr[p]] = {lst, k, base + 64'(b)};
         wr[p]++;
      end
   endtask

   // Call mid-cycle: log output beat, then step one clock and move sources.
   task automatic advance();
      logic [NP-1:0] hs;
      if (m_tvalid && m_tready && nlog < 64) begin
         log_data[nlog] = m_tdata;
         log_port[nlog] = int'(grant_id);
         log_cyc[nlog]  = cyc;
         nlog++;
      end
      hs = s_tvalid & s_tready;
      @(posedge clk156);
      #1;
      for (int i = 0; i < NP; i++)
         if (hs[i]) rd[i]++;
      cyc++;
      present_all();
   endtask

   task automatic test_reset();
      push(1, 1, 64'hDEAD, 8'hFF);
      present_all();
      #2;
      n_total++;
      if (m_tvalid !== 1'b0) $display("FAIL rst_tvalid got %0h want 0", m_tvalid);
      else n_pass++;
      n_total++;
      if (m_tdata !== 64'h0) $display("FAIL rst_tdata got %0h want 0", m_tdata);
      else n_pass++;
      n_total++;
      if (s_tready !== 3'b000) $display("FAIL rst_tready got %0b want 000", s_tready);
      else n_pass++;
      n_total++;
      if (busy !== 1'b0) $display("FAIL rst_busy got %0h want 0", busy);
      else n_pass++;
      n_total++;
      if (grant_id !== 2'd0) $display("FAIL rst_grant got %0d want 0", grant_id);
      else n_pass++;
      clear_src();
      @(posedge clk156);
      #1;
      aresetn = 1'b1;
   endtask

   task automatic test_single_frame();
      nlog = 0;
      cyc  = 0;
      push(1, 3, 64'h11, 8'h0F);
      present_all();
      @(negedge clk156);
      n_total++;
      if (busy !== 1'b0) $display("FAIL sf_idle_busy got %0h want 0", busy);
      else n_pass++;
      n_total++;
      if (m_tvalid !== 1'b0) $display("FAIL sf_idle_tvalid got %0h want 0", m_tvalid);
      else n_pass++;
      n_total++;
      if (s_tready !== 3'b000) $display("FAIL sf_idle_tready got %0b want 000", s_tready);
      else n_pass++;
      advance();
      @(negedge clk156);
      n_total++;
      if (grant_id !== 2'd1) $display("FAIL sf_grant got %0d want 1", grant_id);
      else n_pass++;
      n_total++;
      if (busy !== 1'b1) $display("FAIL sf_busy got %0h want 1", busy);
      else n_pass++;
      n_total++;
      if (m_tdata !== 64'h11) $display("FAIL sf_beat0 got %0h want 11", m_tdata);
      else n_pass++;
      n_total++;
      if (s_tready !== 3'b010) $display("FAIL sf_tready got %0b want 010", s_tready);
      else n_pass++;
      advance();
      @(negedge clk156);
      n_total++;
      if (m_tdata !== 64'h12) $display("FAIL sf_beat1 got %0h want 12", m_tdata);
      else n_pass++;
      advance();
      @(negedge clk156);
      n_total++;
      if (m_tdata !== 64'h13) $display("FAIL sf_beat2 got %0h want 13", m_tdata);
      else n_pass++;
      n_total++;
      if (m_tkeep !== 8'h0F) $display("FAIL sf_keep got %0h want 0f", m_tkeep);
      else n_pass++;
      n_total++;
      if (m_tlast !== 1'b1) $display("FAIL sf_last got %0h want 1", m_tlast);
      else n_pass++;
      advance();
      @(negedge clk156);
      n_total++;
      if (busy !== 1'b0) $display("FAIL sf_end_busy got %0h want 0", busy);
      else n_pass++;
      n_total++;
      if (m_tvalid !== 1'b0 || m_tdata !== 64'h0)
         $display("FAIL sf_end_out got v=%0h d=%0h want v=0 d=0", m_tvalid, m_tdata);
      else n_pass++;
      n_total++;
      if (nlog !== 3) $display("FAIL sf_beats got %0d want 3", nlog);
      else n_pass++;
      advance();
   endtask

   task automatic test_round_robin();
      logic [63:0] ed [8] = '{64'h100, 64'h101, 64'h200, 64'h201,
                              64'h102, 64'h103, 64'h202, 64'h203};
      int ep [8] = '{0, 0, 1, 1, 0, 0, 1, 1};
      int ec [8] = '{1, 2, 4, 5, 7, 8, 10, 11};
      nlog = 0;
      cyc  = 0;
      push(0, 2, 64'h100, 8'hFF);
      push(0, 2, 64'h102, 8'hFF);
      push(1, 2, 64'h200, 8'hFF);
      push(1, 2, 64'h202, 8'hFF);
      present_all();
      for (int c = 0; c < 16; c++) begin
         @(negedge clk156);
         advance();
      end
      n_total++;
      if (nlog !== 8) $display("FAIL rr_beats got %0d want 8", nlog);
      else n_pass++;
      for (int k = 0; k < 8; k++) begin
         n_total++;
         if (log_data[k] !== ed[k])
            $display("FAIL rr_data%0d got %0h want %0h", k, log_data[k], ed[k]);
         else n_pass++;
         n_total++;
         if (log_port[k] !== ep[k])
            $display("FAIL rr_port%0d got %0d want %0d", k, log_port[k], ep[k]);
         else n_pass++;
         n_total++;
         if (log_cyc[k] !== ec[k])
            $display("FAIL rr_cyc%0d got %0d want %0d", k, log_cyc[k], ec[k]);
         else n_pass++;
      end
   endtask

   task automatic test_stall();
      logic [7:0] pat = 8'b1111_0011;
      nlog = 0;
      cyc  = 0;
      push(0, 4, 64'h300, 8'hFF);
      present_all();
      for (int c = 0; c < 8; c++) begin
         m_tready = pat[c];
         @(negedge clk156);
         if (c == 2 || c == 3) begin
            n_total++;
            if (m_tdata !== 64'h301 || m_tvalid !== 1'b1)
               $display("FAIL st_hold%0d got v=%0h d=%0h want v=1 d=301",
                        c, m_tvalid, m_tdata);
            else n_pass++;
            n_total++;
            if (s_tready !== 3'b000)
               $display("FAIL st_rdy%0d got %0b want 000", c, s_tready);
            else n_pass++;
         end
         if (c == 4) begin
            n_total++;
            if (m_tdata !== 64'h301 || s_tready !== 3'b001)
               $display("FAIL st_resume got d=%0h r=%0b want d=301 r=001",
                        m_tdata, s_tready);
            else n_pass++;
         end
         advance();
      end
      m_tready = 1'b1;
      n_total++;
      if (nlog !== 4) $display("FAIL st_beats got %0d want 4", nlog);
      else n_pass++;
      for (int k = 0; k < 4; k++) begin
         n_total++;
         if (log_data[k] !== 64'h300 + 64'(k))
            $display("FAIL st_data%0d got %0h want %0h", k, log_data[k],
                     64'h300 + 64'(k));
         else n_pass++;
      end
`ifdef MAC_TX_ARBITER_STATS_EN
      n_total++;
      if (stall_count !== 32'd2)
         $display("FAIL st_count got %0d want 2", stall_count);
      else n_pass++;
`endif
   endtask

   task automatic test_hold_grant();
      nlog = 0;
      cyc  = 0;
      push(0, 3, 64'h400, 8'hFF);
      present_all();
      for (int c = 0; c < 8; c++) begin
         if (c == 2) begin
            push(1, 1, 64'h500, 8'h3F);
            present_all();
         end
         @(negedge clk156);
         if (c == 2 || c == 3) begin
            n_total++;
            if (s_tready[1] !== 1'b0 || grant_id !== 2'd0)
               $display("FAIL hg_hold%0d got r1=%0h g=%0d want r1=0 g=0",
                        c, s_tready[1], grant_id);
            else n_pass++;
         end
         if (c == 4) begin
            n_total++;
            if (m_tvalid !== 1'b0 || s_tready !== 3'b000)
               $display("FAIL hg_bubble got v=%0h r=%0b want v=0 r=000",
                        m_tvalid, s_tready);
            else n_pass++;
         end
         if (c == 5) begin
            n_total++;
            if (grant_id !== 2'd1) $display("FAIL hg_grant got %0d want 1", grant_id);
            else n_pass++;
            n_total++;
            if (m_tdata !== 64'h500 || m_tkeep !== 8'h3F || m_tlast !== 1'b1)
               $display("FAIL hg_beat got d=%0h k=%0h l=%0h want d=500 k=3f l=1",
                        m_tdata, m_tkeep, m_tlast);
            else n_pass++;
         end
         if (c == 6) begin
            n_total++;
            if (busy !== 1'b0) $display("FAIL hg_single got %0h want 0", busy);
            else n_pass++;
         end
         advance();
      end
      n_total++;
      if (nlog !== 4) $display("FAIL hg_beats got %0d want 4", nlog);
      else n_pass++;
   endtask

   task automatic test_reset_mid();
      nlog = 0;
      cyc  = 0;
      push(0, 4, 64'h600, 8'hFF);
      push(1, 2, 64'h700, 8'hFF);
      present_all();
      for (int c = 0; c < 2; c++) begin
         @(negedge clk156);
         advance();
      end
      @(negedge clk156);
      n_total++;
      if (m_tdata !== 64'h601) $display("FAIL rm_inflight got %0h want 601", m_tdata);
      else n_pass++;
      #1;
      aresetn = 1'b0;
      #1;
      n_total++;
      if (m_tvalid !== 1'b0 || busy !== 1'b0 || s_tready !== 3'b000)
         $display("FAIL rm_async got v=%0h b=%0h r=%0b want 0 0 000",
                  m_tvalid, busy, s_tready);
      else n_pass++;
      clear_src();
      push(0, 2, 64'h610, 8'hFF);
      push(1, 2, 64'h710, 8'hFF);
      present_all();
      @(posedge clk156);
      #1;
      aresetn = 1'b1;
      nlog = 0;
      cyc  = 0;
      @(negedge clk156);
      advance();
      @(negedge clk156);
      n_total++;
      if (grant_id !== 2'd0 || m_tdata !== 64'h610)
         $display("FAIL rm_restart got g=%0d d=%0h want g=0 d=610",
                  grant_id, m_tdata);
      else n_pass++;
      for (int c = 0; c < 6; c++) begin
         advance();
         @(negedge clk156);
      end
      advance();
      n_total++;
      if (nlog !== 4 || log_data[2] !== 64'h710)
         $display("FAIL rm_drain got n=%0d d2=%0h want n=4 d2=710",
                  nlog, log_data[2]);
      else n_pass++;
   endtask

   task automatic test_stats();
      logic [63:0] ed [11] = '{64'h800, 64'h900, 64'h901, 64'h810,
                               64'h910, 64'h911, 64'h820, 64'h920,
                               64'h921, 64'h830, 64'h840};
      aresetn = 1'b0;
      clear_src();
      @(posedge clk156);
      #1;
      aresetn = 1'b1;
      for (int f = 0; f < 5; f++)
         push(0, 1, 64'h800 + 64'(f * 16), 8'hFF);
      for (int f = 0; f < 3; f++)
         push(1, 2, 64'h900 + 64'(f * 16), 8'hFF);
      present_all();
      nlog = 0;
      cyc  = 0;
      for (int c = 0; c < 60; c++) begin
         if (nlog == 11 && !busy) break;
         @(negedge clk156);
         advance();
      end
      n_total++;
      if (nlog !== 11 || busy !== 1'b0)
         $display("FAIL sc_drain got n=%0d b=%0h want n=11 b=0", nlog, busy);
      else n_pass++;
      for (int k = 0; k < 11; k++) begin
         n_total++;
         if (log_data[k] !== ed[k])
            $display("FAIL sc_data%0d got %0h want %0h", k, log_data[k], ed[k]);
         else n_pass++;
      end
`ifdef MAC_TX_ARBITER_STATS_EN
      n_total++;
      if (frame_count[31:0] !== 32'd5)
         $display("FAIL sc_fc0 got %0d want 5", frame_count[31:0]);
      else n_pass++;
      n_total++;
      if (frame_count[63:32] !== 32'd3)
         $display("FAIL sc_fc1 got %0d want 3", frame_count[63:32]);
      else n_pass++;
      n_total++;
      if (frame_count[95:64] !== 32'd0)
         $display("FAIL sc_fc2 got %0d want 0", frame_count[95:64]);
      else n_pass++;
      n_total++;
      if (stall_count !== 32'd0)
         $display("FAIL sc_stall got %0d want 0", stall_count);
      else n_pass++;
`endif
   endtask

   initial begin
      n_pass   = 0;
      n_total  = 0;
      nlog     = 0;
      cyc      = 0;
      aresetn  = 1'b0;
      m_tready = 1'b1;
      s_tdata  = '0;
      s_tkeep  = '0;
      s_tvalid = '0;
      s_tlast  = '0;
      clear_src();
      test_reset();
      test_single_frame();
      test_round_robin();
      test_stall();
      test_hold_grant();
      test_reset_mid();
      test_stats();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/mac_tx_arbiter.md
Name: mac_tx_arbiter

Overview:
- Packet-granular round-robin arbiter that shares the single 64-bit AXI4-Stream TX input of the network module between NUM_PORTS requesters (e.g. UDP offload, ARP responder, ICMP).
- Sits in the clk156 domain, directly upstream of the network module tx_axis_* port.
- Once a port is granted, its whole frame (up to and including tlast) is passed through without interleaving.

Parameters:
- NUM_PORTS, 2, number of requesting streams; legal range 2..8.
- GRANT_W, 3, width of grant_id; must satisfy 2^GRANT_W >= NUM_PORTS.

Ports:
- clk156  in  1  156.25 MHz core clock; all logic on rising edge.
- aresetn  in  1  asynchronous, active-low reset.
- s_axis_tdata  in  NUM_PORTS*64  requester data; port i occupies bits [64*i+63:64*i].
- s_axis_tkeep  in  NUM_PORTS*8  requester byte enables, packed the same way.
- s_axis_tvalid  in  NUM_PORTS  per-port valid.
- s_axis_tlast  in  NUM_PORTS  per-port end of frame.
- s_axis_tready  out  NUM_PORTS  per-port ready.
- m_axis_tdata  out  64  data to network module tx_axis_tdata.
- m_axis_tkeep  out  8  byte enables.
- m_axis_tvalid  out  1  output valid.
- m_axis_tlast  out  1  output end of frame.
- m_axis_tready  in  1  ready from network module tx_axis_tready.
- grant_id  out  GRANT_W  index of the port currently granted; valid while busy=1.
- busy  out  1  high while a frame is in flight (STREAM state).

Behaviour:
- Clock and reset: single clock clk156; reset aresetn is asynchronous, active-low.
- Reset values: state=IDLE, last_grant=NUM_PORTS-1 (so port 0 wins first), grant_id=0, busy=0, m_axis_tvalid=0, s_axis_tready=0. m_axis_tdata, tkeep and tlast are 0 while not in STREAM.
- IDLE state:
  - all s_axis_tready=0, m_axis_tvalid=0.
  - If any s_axis_tvalid bit is 1, the winner is the first asserted port searching (last_grant+1) mod NUM_PORTS upward with wrap-around.
  - grant_id<=winner, busy<=1, next state STREAM.
  - Arbitration latency: one cycle from tvalid to the first possible beat.
- STREAM state:
  - Combinational pass-through of port g=grant_id: m_axis_tdata/tkeep/tlast/tvalid = port g signals.
  - s_axis_tready[g] = m_axis_tready; all other s_axis_tready=0.
  - Zero-cycle datapath latency.
  - A beat transfers when m_axis_tvalid & m_axis_tready.
  - On a transfer with m_axis_tlast=1: last_grant<=g, busy<=0, next state IDLE.
  - Exactly one bubble cycle between consecutive frames.
- Requester deasserts tvalid mid-frame: grant is held with no timeout; m_axis_tvalid follows it low.
- Downstream stall (m_axis_tready=0): state, grant and all inputs are held; no beat is dropped or duplicated.
- Single-beat frame (tvalid and tlast on the first beat): STREAM lasts one cycle if tready=1.
- Requests that appear or disappear during STREAM do not affect the current grant.
- A port that drops tvalid before being granted is simply skipped.
- Fairness: with all ports continuously requesting, grants rotate 0,1,..,N-1,0. No port waits more than NUM_PORTS-1 frames.
- Reset mid-frame: outputs deassert immediately (asynchronous), the partial frame is truncated, and arbitration restarts at port 0.
- Assertions (simulation only): m_axis_tdata/tkeep/tlast stable while m_axis_tvalid & ~m_axis_tready; at most one s_axis_tready bit set.

Optional Feature:
- Macro: MAC_TX_ARBITER_STATS_EN.
- When defined:
  - Adds output frame_count of width NUM_PORTS*32: per-port 32-bit counters of completed frames (tlast handshakes).
  - Adds output stall_count of width 32: counts cycles with busy & m_axis_tvalid & ~m_axis_tready.
  - All counters reset to 0 on aresetn, wrap from 0xFFFFFFFF to 0, and are not saturating.
- When undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset then idle; port 1 sends a 3-beat frame (tdata 0x11,0x12,0x13; last beat tkeep=0x0F), m_axis_tready=1 -> grant_id=1 one cycle after tvalid; m_axis sees 0x11,0x12,0x13 on consecutive cycles; tlast on 0x13 with tkeep 0x0F; busy falls the cycle after.
- Ports 0 and 1 both continuously offer 2-beat frames -> output frame order 0,1,0,1; exactly one idle cycle between frames; no interleaved beats.
- Port 0 frame in flight; m_axis_tready toggles 1,0,0,1 -> m_axis_tdata held during the stall cycles; s_axis_tready[0] mirrors tready; 4 beats in gives 4 beats out; with the macro on, stall_count=2.
- Port 1 asserts tvalid while port 0 is mid-frame -> s_axis_tready[1] stays 0 until port 0 tlast completes; port 1 is granted next.
- aresetn pulsed low during beat 2 of a 4-beat frame -> m_axis_tvalid=0 immediately; after release, with ports 0 and 1 both valid, port 0 is granted first.
- With MAC_TX_ARBITER_STATS_EN defined: 5 frames from port 0 and 3 from port 1 -> frame_count[31:0]=5, frame_count[63:32]=3.
